// File: rtl/cmac_pkg.sv
// Shared types and helpers for the CMAC result drain: FP16 field widths,
// drain FSM states and {real,imag} half extraction / NaN detection.
package cmac_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int EXP_W      = 5;
    localparam int MAN_W      = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REAL = 2'd1,
        IMAG = 2'd2
    } drain_state_e;

    function automatic logic [DATA_WIDTH-1:0] re_of(input logic [2*DATA_WIDTH-1:0] w);
        return w[2*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] im_of(input logic [2*DATA_WIDTH-1:0] w);
        return w[DATA_WIDTH-1:0];
    endfunction

    // Exponent all ones with a non-zero mantissa; infinities are not NaN.
    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return (x[DATA_WIDTH-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
    endfunction
endpackage

// File: rtl/cmac_drain_fifo.sv
// Small result FIFO for the CMAC drain. Exposes the head entry and the entry
// behind it so the drain can load its output register in the same cycle as a pop.
module cmac_drain_fifo
    import cmac_pkg::*;
#(
    parameter int WIDTH = 2*DATA_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         second,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_plus1;
    logic [AW:0]      count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);
    assign head         = mem[rd_ptr_reg];
    assign second       = mem[rd_ptr_plus1];
    assign count        = count_reg;
endmodule

// File: rtl/cmac_fp_drain.sv
// CMAC result drain: captures issued results one cycle after issue, buffers them and
// serialises each {real,imag} word as two beats. Optional out_nan via CMAC_DRAIN_NAN_FLAG_EN.
module cmac_fp_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_vld,
    input  logic                    issue_sel,
    output logic                    issue_rdy,
    input  logic [2*DATA_WIDTH-1:0] mul_in,
    input  logic [2*DATA_WIDTH-1:0] add_in,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_imag,
    output logic                    ovf_err
`ifdef CMAC_DRAIN_NAN_FLAG_EN
    ,
    output logic                    out_nan
`endif
);
    import cmac_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]           fifo_count;
    logic [CW:0]             credit_used;
    logic [2*DATA_WIDTH-1:0] head;
    logic [2*DATA_WIDTH-1:0] second;
    logic [2*DATA_WIDTH-1:0] push_data;
    logic [2*DATA_WIDTH-1:0] next_word;
    logic                    push;
    logic                    pop;
    logic                    inflight_reg;
    logic                    sel_reg;
    logic                    ovf_err_reg;
    drain_state_e            state_reg;
    drain_state_e            state_next;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic [DATA_WIDTH-1:0]   out_data_next;
    logic                    out_imag_reg;
    logic                    out_imag_next;

    // Issue tracking: an accepted issue produces a result on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            sel_reg      <= 1'b0;
            ovf_err_reg  <= 1'b0;
        end else begin
            inflight_reg <= issue_vld & issue_rdy;
            sel_reg      <= issue_sel;
            if (issue_vld && !issue_rdy) begin
                ovf_err_reg <= 1'b1;
            end
        end
    end

    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
    assign issue_rdy   = credit_used < (CW+1)'(DEPTH);
    assign ovf_err     = ovf_err_reg;

    assign push      = inflight_reg;
    assign push_data = sel_reg ? add_in : mul_in;
    assign pop       = (state_reg == IMAG) && out_rdy;

    cmac_drain_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .second    (second),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            out_data_reg <= '0;
            out_imag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            out_data_reg <= out_data_next;
            out_imag_reg <= out_imag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (fifo_count != '0) state_next = REAL;
            REAL: if (out_rdy) state_next = IMAG;
            IMAG: begin
                if (out_rdy) begin
                    // Entries left after the pop include a result being pushed right now.
                    state_next = ((fifo_count > CW'(1)) || inflight_reg) ? REAL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // After a pop the new head is either the queued second entry or the word being pushed.
    assign next_word = (fifo_count > CW'(1)) ? second : push_data;

    always_comb begin
        out_vld       = (state_reg != IDLE);
        out_data_next = out_data_reg;
        out_imag_next = out_imag_reg;
        case (state_next)
            REAL: begin
                out_data_next = re_of(pop ? next_word : head);
                out_imag_next = 1'b0;
            end
            IMAG: begin
                out_data_next = im_of(head);
                out_imag_next = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_data = out_data_reg;
    assign out_imag = out_imag_reg;

`ifdef CMAC_DRAIN_NAN_FLAG_EN
    logic out_nan_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_nan_reg <= 1'b0;
        end else begin
            out_nan_reg <= is_nan(out_data_next);
        end
    end

    assign out_nan = out_nan_reg;
`endif
endmodule

// File: tb/tb_cmac_fp_drain.sv
// Directed self-checking bench for cmac_fp_drain: issue/capture latency, operand select,
// credit throttling, overflow, output hold, mid-word reset and the optional NaN flag.
module tb_cmac_fp_drain;
    localparam int W = 16;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_vld;
    logic          issue_sel;
    logic          issue_rdy;
    logic [2*W-1:0] mul_in;
    logic [2*W-1:0] add_in;
    logic          out_vld;
    logic          out_rdy;
    logic [W-1:0]  out_data;
    logic          out_imag;
    logic          ovf_err;
`ifdef CMAC_DRAIN_NAN_FLAG_EN
    logic          out_nan;
`endif

    int checks   = 0;
    int failures = 0;
    int acc;
    logic [31:0] w;

    always #5 clk = ~clk;

    cmac_fp_drain #(
        .DATA_WIDTH (W),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_vld (issue_vld),
        .issue_sel (issue_sel),
        .issue_rdy (issue_rdy),
        .mul_in    (mul_in),
        .add_in    (add_in),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_imag  (out_imag),
        .ovf_err   (ovf_err)
`ifdef CMAC_DRAIN_NAN_FLAG_EN
        ,
        .out_nan   (out_nan)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input int base, input int k);
        return {16'(base + 2*k), 16'(base + 2*k + 1)};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; issue_vld = 1'b0; issue_sel = 1'b0;
        mul_in = '0; add_in = '0; out_rdy = 1'b0;
        repeat (3) tick;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_imag", 32'(out_imag), 32'd0);
        chk("rst_ovf_err", 32'(ovf_err), 32'd0);
        chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
`ifdef CMAC_DRAIN_NAN_FLAG_EN
        chk("rst_out_nan", 32'(out_nan), 32'd0);
`endif
        rst_n = 1'b1;
        tick;

        // 1: mul capture, beats at cycles 2 and 3
        mul_in = {16'h3C00, 16'h4000}; issue_sel = 1'b0; issue_vld = 1'b1; out_rdy = 1'b1;
        tick;
        issue_vld = 1'b0;
        chk("t1_c0_vld", 32'(out_vld), 32'd0);
        tick;
        chk("t1_c1_vld", 32'(out_vld), 32'd0);
        tick;
        chk("t1_real_vld", 32'(out_vld), 32'd1);
        chk("t1_real_data", 32'(out_data), 32'h3C00);
        chk("t1_real_imag", 32'(out_imag), 32'd0);
        tick;
        chk("t1_imag_vld", 32'(out_vld), 32'd1);
        chk("t1_imag_data", 32'(out_data), 32'h4000);
        chk("t1_imag_imag", 32'(out_imag), 32'd1);
        tick;
        chk("t1_idle_vld", 32'(out_vld), 32'd0);

        // 2: add selected, mul ignored
        mul_in = {16'h1234, 16'h5678}; add_in = {16'hC000, 16'h0000};
        issue_sel = 1'b1; issue_vld = 1'b1;
        tick;
        issue_vld = 1'b0; issue_sel = 1'b0;
        tick;
        tick;
        chk("t2_real_data", 32'(out_data), 32'hC000);
        chk("t2_real_imag", 32'(out_imag), 32'd0);
        tick;
        chk("t2_imag_data", 32'(out_data), 32'h0000);
        chk("t2_imag_imag", 32'(out_imag), 32'd1);
        tick;
        chk("t2_idle_vld", 32'(out_vld), 32'd0);

        // 3: stalled output, issue whenever allowed
        out_rdy = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            issue_vld = issue_rdy;
            if (issue_rdy) acc++;
            tick;
            issue_vld = 1'b0;
            mul_in = wd(16'h1000, acc - 1);
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_issue_rdy", 32'(issue_rdy), 32'd0);
        chk("t3_ovf_err", 32'(ovf_err), 32'd0);
        out_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            w = wd(16'h1000, j / 2);
            chk("t3_beat_vld", 32'(out_vld), 32'd1);
            chk("t3_beat_data", 32'(out_data), (j % 2 == 0) ? 32'(w[31:16]) : 32'(w[15:0]));
            chk("t3_beat_imag", 32'(out_imag), 32'(j % 2));
            tick;
        end
        chk("t3_drained_vld", 32'(out_vld), 32'd0);

        // 4: overflow while full
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_vld = 1'b1;
            tick;
            issue_vld = 1'b0;
            mul_in = wd(16'h2000, i);
        end
        chk("t4_full_rdy", 32'(issue_rdy), 32'd0);
        chk("t4_pre_ovf", 32'(ovf_err), 32'd0);
        issue_vld = 1'b1;
        tick;
        issue_vld = 1'b0;
        mul_in = 32'hDEADBEEF;
        tick;
        chk("t4_ovf_err", 32'(ovf_err), 32'd1);
        out_rdy = 1'b1;
        for (int j = 0; j < 8; j++) begin
            w = wd(16'h2000, j / 2);
            chk("t4_beat_vld", 32'(out_vld), 32'd1);
            chk("t4_beat_data", 32'(out_data), (j % 2 == 0) ? 32'(w[31:16]) : 32'(w[15:0]));
            tick;
        end
        chk("t4_no_drop_vld", 32'(out_vld), 32'd0);
        tick;
        chk("t4_no_drop_vld2", 32'(out_vld), 32'd0);
        chk("t4_ovf_sticky", 32'(ovf_err), 32'd1);
        chk("t4_rdy_back", 32'(issue_rdy), 32'd1);

        // 5: hold in IMAG, then reset mid-word
        out_rdy = 1'b0; issue_vld = 1'b1;
        tick;
        mul_in = {16'hABCD, 16'h1234};
        tick;
        mul_in = {16'h5555, 16'h6666}; issue_vld = 1'b0;
        tick;
        chk("t5_real_data", 32'(out_data), 32'hABCD);
        out_rdy = 1'b1;
        tick;
        out_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_vld", 32'(out_vld), 32'd1);
            chk("t5_hold_data", 32'(out_data), 32'h1234);
            chk("t5_hold_imag", 32'(out_imag), 32'd1);
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(out_vld), 32'd0);
        chk("t5_rst_data", 32'(out_data), 32'd0);
        chk("t5_rst_ovf", 32'(ovf_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("t5_no_stale_vld", 32'(out_vld), 32'd0);
        end
        chk("t5_post_rdy", 32'(issue_rdy), 32'd1);

`ifdef CMAC_DRAIN_NAN_FLAG_EN
        // 6: NaN on real half, infinity on imag half
        mul_in = {16'h7E00, 16'h7C00}; issue_vld = 1'b1;
        tick;
        issue_vld = 1'b0;
        tick;
        tick;
        chk("t6_real_data", 32'(out_data), 32'h7E00);
        chk("t6_real_nan", 32'(out_nan), 32'd1);
        tick;
        chk("t6_imag_data", 32'(out_data), 32'h7C00);
        chk("t6_imag_nan", 32'(out_nan), 32'd0);
        tick;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
